// File: rtl/controle_processador.sv
// -----------------------------------------------------------------------------
// controle_processador
//
// Multi-cycle control unit for the 8-bit processor datapath. Latches an
// instruction word from Entrada in T0 and sequences it through timing states
// T0..T3, producing the register-bank, bus-mux and ALU control strobes.
//
// Instruction word: op = IR[7:5], IR[4] reserved, X = IR[3:2] (destination),
// Y = IR[1:0] (source).
//   000 mv  Rx,Ry   001 mvi Rx,#D   010 add Rx,Ry   011 sub Rx,Ry
//   100 and Rx,Ry   101..111 nop
//
// Ports:
//   Clock    in   system clock, rising edge
//   Reset    in   synchronous active-high reset; forces every output to 0
//   Run      in   start request, sampled only in T0
//   Entrada  in   instruction word (T0) / immediate data (T1 of mvi)
//   IRin     out  instruction register load strobe
//   RegIn    out  one-hot register load enable
//   RegOut   out  one-hot register-to-bus select
//   DINout   out  selects Entrada onto the bus
//   Ain      out  load ALU operand register A
//   Gin      out  load ALU result register G
//   Gout     out  selects G onto the bus
//   AluOp    out  00 add, 01 sub, 10 and (nonzero only in T2)
//   Done     out  instruction retires this cycle
//   Estado   out  current timing state (T0=0 .. T3=3)
// -----------------------------------------------------------------------------
module controle_processador #(
  parameter int LARGURA  = 8,
  parameter int NUM_REGS = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Run,
  input  logic [LARGURA-1:0]  Entrada,
  output logic                IRin,
  output logic [NUM_REGS-1:0] RegIn,
  output logic [NUM_REGS-1:0] RegOut,
  output logic                DINout,
  output logic                Ain,
  output logic                Gin,
  output logic                Gout,
  output logic [1:0]          AluOp,
  output logic                Done,
  output logic [1:0]          Estado
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } estado_t;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_NOP5 = 3'b101,
    OP_NOP6 = 3'b110,
    OP_NOP7 = 3'b111
  } opcode_t;

  estado_t            estado;
  logic [LARGURA-1:0] ir;

  opcode_t    op;
  logic [1:0] campo_x;
  logic [1:0] campo_y;
  logic       op_alu;

  assign op      = opcode_t'(ir[7:5]);
  assign campo_x = ir[3:2];
  assign campo_y = ir[1:0];
  assign op_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);

  // IR[4] is reserved in the instruction format and never decoded.
  logic unused_ir4;
  assign unused_ir4 = ir[4];

  // 2-bit register field to one-hot select.
  function automatic logic [NUM_REGS-1:0] decodifica(input logic [1:0] campo);
    logic [NUM_REGS-1:0] um;
    um = '0;
    um[0] = 1'b1;
    return um << campo;
  endfunction

  // ---------------------------------------------------------------------------
  // State and instruction register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado <= T0;
      ir     <= '0;
    end else begin
      case (estado)
        T0: begin
          if (Run) begin
            ir     <= Entrada;
            estado <= T1;
          end
        end
        T1:      estado <= op_alu ? T2 : T0;
        T2:      estado <= T3;
        T3:      estado <= T0;
        default: estado <= T0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control outputs: Moore decode of (estado, IR) plus IRin = Run in T0.
  // Reset gates everything to zero, so an aborted instruction never shows Done.
  // ---------------------------------------------------------------------------
  always_comb begin
    IRin   = 1'b0;
    RegIn  = '0;
    RegOut = '0;
    DINout = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    Gout   = 1'b0;
    AluOp  = 2'b00;
    Done   = 1'b0;
    Estado = '0;

    if (!Reset) begin
      Estado = estado;
      case (estado)
        T0: begin
          IRin = Run;
        end

        T1: begin
          case (op)
            OP_MV: begin
              RegOut = decodifica(campo_y);
              RegIn  = decodifica(campo_x);
              Done   = 1'b1;
            end
            OP_MVI: begin
              DINout = 1'b1;
              RegIn  = decodifica(campo_x);
              Done   = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              RegOut = decodifica(campo_x);
              Ain    = 1'b1;
            end
            default: begin
              Done = 1'b1;
            end
          endcase
        end

        // T2/T3 are only entered from an ALU opcode.
        T2: begin
          RegOut = decodifica(campo_y);
          Gin    = 1'b1;
          case (op)
            OP_SUB:  AluOp = 2'b01;
            OP_AND:  AluOp = 2'b10;
            default: AluOp = 2'b00;
          endcase
        end

        T3: begin
          Gout  = 1'b1;
          RegIn = decodifica(campo_x);
          Done  = 1'b1;
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_processador.sv
module tb_controle_processador;

  logic       Clock;
  logic       Reset;
  logic       Run;
  logic [7:0] Entrada;
  logic       IRin;
  logic [3:0] RegIn;
  logic [3:0] RegOut;
  logic       DINout;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic [1:0] AluOp;
  logic       Done;
  logic [1:0] Estado;

  controle_processador #(
    .LARGURA  (8),
    .NUM_REGS (4)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Run     (Run),
    .Entrada (Entrada),
    .IRin    (IRin),
    .RegIn   (RegIn),
    .RegOut  (RegOut),
    .DINout  (DINout),
    .Ain     (Ain),
    .Gin     (Gin),
    .Gout    (Gout),
    .AluOp   (AluOp),
    .Done    (Done),
    .Estado  (Estado)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       irin;
    logic [3:0] regin;
    logic [3:0] regout;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [1:0] aluop;
    logic       done;
    logic [1:0] estado;
  } outv_t;

  outv_t exp_q[$];
  string nome_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    fim    = 0;

  function automatic outv_t ov(input logic irin, input logic [3:0] regin,
                               input logic [3:0] regout, input logic dinout,
                               input logic ain, input logic gin, input logic gout,
                               input logic [1:0] aluop, input logic done,
                               input logic [1:0] estado);
    outv_t v;
    v.irin = irin; v.regin = regin; v.regout = regout; v.dinout = dinout;
    v.ain = ain; v.gin = gin; v.gout = gout; v.aluop = aluop;
    v.done = done; v.estado = estado;
    return v;
  endfunction

  // One clock cycle of stimulus: inputs are applied just after the rising
  // edge and the expected outputs for that cycle go into the scoreboard.
  task automatic step(input string nm, input logic rst, input logic run,
                      input logic [7:0] ent, input outv_t e);
    @(posedge Clock);
    #1;
    Reset   = rst;
    Run     = run;
    Entrada = ent;
    exp_q.push_back(e);
    nome_q.push_back(nm);
  endtask

  // Monitor: samples on the falling edge, pops and compares.
  always @(negedge Clock) begin
    outv_t act;
    outv_t e;
    string nm;
    int    nb;
    act = ov(IRin, RegIn, RegOut, DINout, Ain, Gin, Gout, AluOp, Done, Estado);
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = nome_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s got %b_%b_%b_%b%b%b%b_%b_%b_%0d want %b_%b_%b_%b%b%b%b_%b_%b_%0d",
                 nm, act.irin, act.regin, act.regout, act.dinout, act.ain, act.gin,
                 act.gout, act.aluop, act.done, act.estado, e.irin, e.regin, e.regout,
                 e.dinout, e.ain, e.gin, e.gout, e.aluop, e.done, e.estado);
      end
    end
    if (!fim) begin
      nb = $countones(RegOut) + int'(DINout) + int'(Gout);
      checks++;
      if (nb > 1 || !$onehot0(RegIn) || !$onehot0(RegOut)) begin
        errors++;
        $display("FAIL bus_excl t=%0t got RegOut=%b DINout=%b Gout=%b RegIn=%b want exclusive/one-hot",
                 $time, RegOut, DINout, Gout, RegIn);
      end
    end
  end

  outv_t Z0;

  initial begin
    Reset   = 1'b1;
    Run     = 1'b0;
    Entrada = 8'h00;
    Z0 = ov(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'd0);

    // Reset then idle
    step("rst_a", 1, 0, 8'h00, Z0);
    step("rst_b", 1, 0, 8'h00, Z0);
    for (int i = 0; i < 5; i++) step("idle", 0, 0, 8'h00, Z0);

    // mv R2,R1
    step("mv_t0", 0, 1, 8'b000_0_10_01, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'd0));
    step("mv_t1", 0, 0, 8'h00,          ov(0, 4'b0100, 4'b0010, 0, 0, 0, 0, 2'b00, 1, 2'd1));
    step("mv_back_t0", 0, 0, 8'h00, Z0);

    // mvi R3,#5A
    step("mvi_t0", 0, 1, 8'b001_0_11_00, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'd0));
    step("mvi_t1", 0, 0, 8'h5A,          ov(0, 4'b1000, 4'b0000, 1, 0, 0, 0, 2'b00, 1, 2'd1));
    step("mvi_back_t0", 0, 0, 8'h00, Z0);

    // sub R0,R3
    step("sub_t0", 0, 1, 8'b011_0_00_11, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'd0));
    step("sub_t1", 0, 0, 8'h00,          ov(0, 4'b0000, 4'b0001, 0, 1, 0, 0, 2'b00, 0, 2'd1));
    step("sub_t2", 0, 0, 8'h00,          ov(0, 4'b0000, 4'b1000, 0, 0, 1, 0, 2'b01, 0, 2'd2));
    step("sub_t3", 0, 0, 8'h00,          ov(0, 4'b0001, 4'b0000, 0, 0, 0, 1, 2'b00, 1, 2'd3));
    step("sub_back_t0", 0, 0, 8'h00, Z0);

    // add R1,R2 with Run held high; Entrada changes mid-instruction
    step("add_t0", 0, 1, 8'b010_0_01_10, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'd0));
    step("add_t1", 0, 1, 8'b010_0_01_10, ov(0, 4'b0000, 4'b0010, 0, 1, 0, 0, 2'b00, 0, 2'd1));
    step("add_t2", 0, 1, 8'b110_0_00_00, ov(0, 4'b0000, 4'b0100, 0, 0, 1, 0, 2'b00, 0, 2'd2));
    step("add_t3", 0, 1, 8'b110_0_00_00, ov(0, 4'b0010, 4'b0000, 0, 0, 0, 1, 2'b00, 1, 2'd3));
    // next instruction (nop 110) fetched in the T0 after Done
    step("nop_t0", 0, 1, 8'b110_0_00_00, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'd0));
    step("nop_t1", 0, 0, 8'h00,          ov(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 1, 2'd1));
    step("nop_back_t0", 0, 0, 8'h00, Z0);

    // and R3,R1 with reset in T2
    step("andrst_t0", 0, 1, 8'b100_0_11_01, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'd0));
    step("andrst_t1", 0, 0, 8'h00,          ov(0, 4'b0000, 4'b1000, 0, 1, 0, 0, 2'b00, 0, 2'd1));
    step("andrst_t2_reset", 1, 0, 8'h00, Z0);
    step("andrst_after_a", 0, 0, 8'h00, Z0);
    step("andrst_after_b", 0, 0, 8'h00, Z0);

    // Reset with Run high: no IRin, no fetch
    step("rst_run", 1, 1, 8'b000_0_01_01, Z0);
    step("rst_run_after", 0, 0, 8'h00, Z0);

    // mv R3,R3 with reserved bit set
    step("mvxx_t0", 0, 1, 8'b000_1_11_11, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'd0));
    step("mvxx_t1", 0, 0, 8'h00,          ov(0, 4'b1000, 4'b1000, 0, 0, 0, 0, 2'b00, 1, 2'd1));

    // and R2,R0 full sequence, then nop 101 and 111 back to back
    step("and_t0", 0, 1, 8'b100_0_10_00, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'd0));
    step("and_t1", 0, 0, 8'h00,          ov(0, 4'b0000, 4'b0100, 0, 1, 0, 0, 2'b00, 0, 2'd1));
    step("and_t2", 0, 0, 8'h00,          ov(0, 4'b0000, 4'b0001, 0, 0, 1, 0, 2'b10, 0, 2'd2));
    step("and_t3", 0, 0, 8'h00,          ov(0, 4'b0100, 4'b0000, 0, 0, 0, 1, 2'b00, 1, 2'd3));
    step("nop5_t0", 0, 1, 8'b101_0_11_11, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'd0));
    step("nop5_t1", 0, 1, 8'b111_0_10_01, ov(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 1, 2'd1));
    step("nop7_t0", 0, 1, 8'b111_0_10_01, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'd0));
    step("nop7_t1", 0, 0, 8'h00,          ov(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 1, 2'd1));
    step("final_t0", 0, 0, 8'h00, Z0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clock);
    @(posedge Clock);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    fim = 1;
    @(posedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_processador.md
Name: controle_processador

Overview:
- Multi-cycle control unit for the 8-bit processor datapath.
- Latches each instruction word from the input bus.
- Sequences it through timing states T0–T3, driving one-hot register-bank mux selects, register load enables, ALU operation and accumulator/result strobes.
- Sits between instruction memory/switch input and the register file, 2:1/N:1 bus muxes and ALU; asserts Done when an instruction retires.

Parameters:
- LARGURA, 8, width of Entrada and the internal instruction register (fixed at 8; other values unsupported).
- NUM_REGS, 4, number of general registers; width of RegIn/RegOut (fixed at 4, matching the 2-bit register fields).

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Run  input  1  start request; sampled only in T0.
- Entrada  input  LARGURA  instruction word in T0; immediate data in T1 of mvi.
- IRin  output  1  instruction register load strobe (for observation).
- RegIn  output  NUM_REGS  one-hot register load enable.
- RegOut  output  NUM_REGS  one-hot register-to-bus mux select.
- DINout  output  1  selects Entrada onto the bus.
- Ain  output  1  load ALU operand register A.
- Gin  output  1  load ALU result register G.
- Gout  output  1  selects G onto the bus.
- AluOp  output  2  00 add, 01 sub, 10 and, 11 unused.
- Done  output  1  instruction completes this cycle.
- Estado  output  2  current timing state (T0=0 … T3=3).

Behaviour:
- Instruction format (IR): op=IR[7:5], IR[4] ignored, X=IR[3:2] destination, Y=IR[1:0] source.
- Opcodes:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#D
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 100 and Rx,Ry
  - 101–111 nop
- Internal registers: Estado (2b) and IR (8b).
- Outputs are combinational from Estado, IR and Run (Moore plus the IRin=Run term in T0).
- T0 (idle/fetch):
  - IRin=Run; all other outputs 0.
  - If Run=1: IR<=Entrada, next T1; else stay T0.
- T1:
  - mv: RegOut[Y]=1, RegIn[X]=1, Done=1, next T0.
  - mvi: DINout=1, RegIn[X]=1, Done=1, next T0.
  - add/sub/and: RegOut[X]=1, Ain=1, next T2.
  - nop: Done=1 only, next T0.
- T2 (ALU ops only): RegOut[Y]=1, Gin=1, AluOp per opcode (add 00, sub 01, and 10), next T3.
- T3 (ALU ops only): Gout=1, RegIn[X]=1, Done=1, next T0.
- AluOp is 00 in every state other than T2.
- Latency (Run sampled high to Done cycle):
  - mv/mvi/nop: 1 cycle.
  - add/sub/and: 3 cycles.
- Back-to-back issue: after Done, T0 is re-entered. Run held high fetches the next instruction on the following edge, so there is one T0 cycle between instructions.
- Run is ignored in T1–T3; IR is stable from T1 until the next T0 fetch.
- Bus exclusivity invariant: in every cycle, at most one of {any RegOut bit, DINout, Gout} is high, and RegOut and RegIn are each zero- or one-hot.
- mv with X==Y is legal: RegOut[X] and RegIn[X] are both high in the same cycle.
- Reset:
  - While Reset=1, all outputs are forced to 0 (including IRin and Done).
  - On the edge: Estado<=T0, IR<=8'h00.
  - Reset mid-instruction aborts it with no Done; the first post-reset cycle is T0 with all outputs 0 unless Run=1.
- Estado value 2'b11 is reached only via ALU ops. No illegal states exist, since all 4 encodings are defined.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles, Run=0 -> Estado=0, all outputs 0. After release with Run=0 for 5 cycles -> still T0, IRin=0.
- mv: Run=1, Entrada=8'b000_0_10_01 -> next cycle Estado=1, RegOut=0010, RegIn=0100, Done=1. Following cycle Estado=0.
- mvi: Entrada=8'b001_0_11_00, Run=1, then Entrada=8'h5A in T1 -> T1: DINout=1, RegIn=1000, Done=1, RegOut=0000.
- sub: Entrada=8'b011_0_00_11 -> T1: RegOut=0001, Ain=1. T2: RegOut=1000, Gin=1, AluOp=01. T3: Gout=1, RegIn=0001, Done=1. Done appears exactly 3 cycles after fetch.
- Run ignored / back-to-back: hold Run=1 through an add; change Entrada in T2 -> IR unchanged, no refetch until T0. Next instruction is fetched in the T0 cycle after Done. Opcode 110 -> Done in T1 with no enables.
- Reset mid-op: assert Reset during T2 of and -> Gin forced 0 that cycle, no Done. Next cycle Estado=0, IR=0. Bench checks the bus-exclusivity invariant every cycle throughout.
